// File: rtl/seq_101_frame_tx_pkg.sv
// Shared definitions for the "101" marker line: state codes used by the
// frame transmitter (and by the matching 101 detector for its A..D codes).
package seq_101_frame_tx_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PRE  = 2'b01;
  localparam logic [1:0] S_DATA = 2'b10;
  localparam logic [1:0] S_GAP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_PRE  = S_PRE,
    ST_DATA = S_DATA,
    ST_GAP  = S_GAP
  } tx_state_t;

  // Largest of three phase lengths; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/seq_101_frame_tx_piso.sv
// Parallel-in serial-out register: parallel load wins over shift,
// shifts left with zero fill, MSB is the serial output.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic         q_msb
);

  logic [W-1:0] sr;

  // Capture a new word on load, otherwise move the next bit up to the MSB.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift_en) begin
      sr <= sr << 1;
    end
  end

  assign q_msb = sr[W-1];

endmodule

// File: rtl/seq_101_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then idle-low gap.
// All outputs are decoded from registered state, counter and shift register.
module seq_101_frame_tx
  import seq_101_frame_tx_pkg::*;
#(
  parameter int               DATA_W   = 8,
  parameter int               PRE_W    = 3,
  parameter logic [PRE_W-1:0] PREAMBLE = 3'b101,
  parameter int               GAP      = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              w,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max3(PRE_W, DATA_W, GAP)) + 1;

  tx_state_t        state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             accept;
  logic             shift_en;
  logic             data_bit;
  logic [PRE_W-1:0] pre_shifted;

  assign accept   = load && ready;
  assign shift_en = (state == ST_DATA);

  piso_shift #(.W(DATA_W)) u_piso (
    .clk      (clk),
    .Reset    (Reset),
    .load     (accept),
    .shift_en (shift_en),
    .d        (data_in),
    .q_msb    (data_bit)
  );

  // State and phase counter; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Phase sequencing: each phase counts down to zero, then reloads for the next.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (load) begin
          next_state = ST_PRE;
          next_cnt   = CNT_W'(PRE_W - 1);
        end
      end
      ST_PRE: begin
        if (cnt == '0) begin
          next_state = ST_DATA;
          next_cnt   = CNT_W'(DATA_W - 1);
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          next_state = ST_GAP;
          next_cnt   = CNT_W'(GAP - 1);
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          next_state = ST_IDLE;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign pre_shifted = PREAMBLE >> cnt;

  // Output decode: line level per phase plus handshake and status flags.
  always_comb begin
    w     = 1'b0;
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_PRE: begin
        w    = pre_shifted[0];
        busy = 1'b1;
      end
      ST_DATA: begin
        w    = data_bit;
        busy = 1'b1;
      end
      ST_GAP: begin
        busy = 1'b1;
        done = (cnt == CNT_W'(GAP - 1));
      end
      default: w = 1'b0;
    endcase
  end

endmodule
